// File: rtl/reg_operand_sequencer.sv
// Operand-fetch / writeback sequencer between issue, the register file and execute.
// A per-register pending scoreboard stalls issue on RAW and WAW hazards against outstanding writebacks.
module reg_operand_sequencer #(
    parameter int addrsize = 5,
    parameter int regsnum  = 32
) (
    input  logic                clk,
    input  logic                rst,
    // issue side
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [addrsize-1:0] iss_ra0,
    input  logic [addrsize-1:0] iss_ra1,
    input  logic [1:0]          iss_use,
    input  logic [addrsize-1:0] iss_wa,
    input  logic                iss_wen,
    // register file read ports
    output logic [addrsize-1:0] ra0,
    output logic [addrsize-1:0] ra1,
    output logic [1:0]          read,
    input  logic [31:0]         rd0,
    input  logic [31:0]         rd1,
    // execute side
    output logic                op_valid,
    input  logic                op_ready,
    output logic [31:0]         op_a,
    output logic [31:0]         op_b,
    output logic [addrsize-1:0] op_wa,
    output logic                op_wen,
    // results (no backpressure)
    input  logic                res0_valid,
    input  logic [addrsize-1:0] res0_wa,
    input  logic [31:0]         res0_data,
    input  logic                res1_valid,
    input  logic [addrsize-1:0] res1_wa,
    input  logic [31:0]         res1_data,
    // register file write ports
    output logic [addrsize-1:0] wa0,
    output logic [addrsize-1:0] wa1,
    output logic [31:0]         wd0,
    output logic [31:0]         wd1,
    output logic [1:0]          write,
    // status
    output logic [regsnum-1:0]  pending,
    output logic                wb_err,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         use_q;
    logic               hazard;
    logic               accept;
    logic [regsnum-1:0] pend_nxt;
    logic               err_now;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and a presented op holds its payload until taken.
    assign hazard = (iss_use[0] & pending[iss_ra0])
                  | (iss_use[1] & pending[iss_ra1])
                  | (iss_wen    & pending[iss_wa]);

    assign iss_ready = (state == IDLE) & ~hazard & ~rst;
    assign accept    = iss_valid & iss_ready;
    assign op_valid  = (state == HOLD);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        ra0       = '0;
        ra1       = '0;
        read      = 2'b00;
        case (state)
            IDLE: begin
                if (!rst) begin
                    ra0 = iss_ra0;
                    ra1 = iss_ra1;
                end
                if (accept) begin
                    read      = iss_use;
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (op_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are latched at accept; operands land one cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            use_q  <= 2'b00;
            op_wa  <= '0;
            op_wen <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
        end else begin
            if (accept) begin
                use_q  <= iss_use;
                op_wa  <= iss_wa;
                op_wen <= iss_wen;
            end
            if (state == READ) begin
                op_a <= use_q[0] ? rd0 : '0;
                op_b <= use_q[1] ? rd1 : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write <= 2'b00;
            wa0   <= '0;
            wa1   <= '0;
            wd0   <= '0;
            wd1   <= '0;
        end else begin
            write <= {res1_valid, res0_valid};
            if (res0_valid) begin
                wa0 <= res0_wa;
                wd0 <= res0_data;
            end
            if (res1_valid) begin
                wa1 <= res1_wa;
                wd1 <= res1_data;
            end
        end
    end

    // Clear on the edge the register file commits the write, so a dependent read never
    // samples the old value; an issue-time set is applied last and therefore wins.
    always_comb begin
        pend_nxt = pending;
        if (write[0]) begin
            pend_nxt[wa0] = 1'b0;
        end
        if (write[1]) begin
            pend_nxt[wa1] = 1'b0;
        end
        if (accept && iss_wen) begin
            pend_nxt[iss_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    assign err_now = (res0_valid & ~pending[res0_wa])
                   | (res1_valid & ~pending[res1_wa])
                   | (res0_valid & res1_valid & (res0_wa == res1_wa));

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else begin
            wb_err <= wb_err | err_now;
        end
    end

endmodule

// File: tb/tb_reg_operand_sequencer.sv
// Randomised and directed bench for reg_operand_sequencer with a register-file model,
// a scoreboard of expected operands/writebacks and a cycle-level behavioural reference.
module tb_reg_operand_sequencer;

    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic          iss_ready;
    logic [AW-1:0] iss_ra0, iss_ra1, iss_wa;
    logic [1:0]    iss_use;
    logic          iss_wen;
    logic [AW-1:0] ra0, ra1;
    logic [1:0]    read;
    logic [31:0]   rd0, rd1;
    logic          op_valid, op_ready;
    logic [31:0]   op_a, op_b;
    logic [AW-1:0] op_wa;
    logic          op_wen;
    logic          res0_valid, res1_valid;
    logic [AW-1:0] res0_wa, res1_wa;
    logic [31:0]   res0_data, res1_data;
    logic [AW-1:0] wa0, wa1;
    logic [31:0]   wd0, wd1;
    logic [1:0]    write;
    logic [NR-1:0] pending;
    logic          wb_err;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    reg_operand_sequencer #(.addrsize(AW), .regsnum(NR)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ra0(iss_ra0), .iss_ra1(iss_ra1), .iss_use(iss_use),
        .iss_wa(iss_wa), .iss_wen(iss_wen),
        .ra0(ra0), .ra1(ra1), .read(read), .rd0(rd0), .rd1(rd1),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_wa(op_wa), .op_wen(op_wen),
        .res0_valid(res0_valid), .res0_wa(res0_wa), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_wa(res1_wa), .res1_data(res1_data),
        .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .write(write),
        .pending(pending), .wb_err(wb_err), .dbg_state(dbg_state)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 3) return 32'h11;
        if (i == 4) return 32'h22;
        return 32'h1000_0000 + 32'(i) * 32'h0101;
    endfunction

    // ---------------- register file (environment) ----------------
    logic [31:0] rf [NR];
    logic        rf_loaded = 1'b0;

    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < NR; i++) rf[i] <= init_val(i);
            rf_loaded <= 1'b1;
        end else begin
            if (read[0]) rd0 <= rf[ra0];
            if (read[1]) rd1 <= rf[ra1];
            if (write[0]) rf[wa0] <= wd0;
            if (write[1]) rf[wa1] <= wd1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic [31:0]   a;
        logic [31:0]   b;
        logic [AW-1:0] wa;
        logic          wen;
    } op_t;
    typedef struct {
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        int            cyc;
    } wb_t;
    typedef struct {
        logic [AW-1:0] wa;
        int            cyc;
    } clr_t;

    op_t  exp_q[$];
    wb_t  wb_q0[$], wb_q1[$];
    clr_t clr_q[$];

    logic [31:0]   m_rf [NR];
    logic [NR-1:0] m_pend = '0;
    logic [NR-1:0] m_owed = '0;
    bit            m_busy = 0;
    int            m_t = 0;
    bit            m_err = 0;
    bit            acc_prev = 0, hs_prev = 0, rst_prev = 0, wen_prev = 0, err_prev = 0;
    logic [AW-1:0] wa_prev = '0;

    bit            exp_iss_ready = 0, exp_op_valid = 0, exp_err = 0;
    logic [1:0]    exp_read = 2'b00;
    logic [NR-1:0] exp_pend = '0;
    bit            mon_en = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Evaluate the current cycle's inputs against the model and record what the DUT must do.
    task automatic commit();
        logic hz;
        hz = (iss_use[0] & m_pend[iss_ra0]) | (iss_use[1] & m_pend[iss_ra1]) | (iss_wen & m_pend[iss_wa]);
        exp_op_valid  = m_busy && (cyc >= m_t + 2);
        exp_iss_ready = !rst && !m_busy && !hz;
        exp_pend      = m_pend;
        exp_err       = m_err;
        acc_prev      = iss_valid && exp_iss_ready;
        exp_read      = acc_prev ? iss_use : 2'b00;
        hs_prev       = exp_op_valid && op_ready && !rst;
        rst_prev      = rst;
        err_prev      = 0;
        if (acc_prev) begin
            exp_q.push_back(op_t'{a: iss_use[0] ? m_rf[iss_ra0] : 32'h0,
                                  b: iss_use[1] ? m_rf[iss_ra1] : 32'h0,
                                  wa: iss_wa, wen: iss_wen});
            wen_prev = iss_wen;
            wa_prev  = iss_wa;
            if (iss_wen) m_owed[iss_wa] = 1'b1;
        end
        if (!rst) begin
            if (res0_valid) begin
                if (!m_pend[res0_wa]) err_prev = 1;
                m_rf[res0_wa] = res0_data;
                m_owed[res0_wa] = 1'b0;
                wb_q0.push_back('{wa: res0_wa, wd: res0_data, cyc: cyc + 1});
                clr_q.push_back('{wa: res0_wa, cyc: cyc + 1});
            end
            if (res1_valid) begin
                if (!m_pend[res1_wa]) err_prev = 1;
                m_rf[res1_wa] = res1_data;
                m_owed[res1_wa] = 1'b0;
                wb_q1.push_back('{wa: res1_wa, wd: res1_data, cyc: cyc + 1});
                clr_q.push_back('{wa: res1_wa, cyc: cyc + 1});
            end
            if (res0_valid && res1_valid && res0_wa == res1_wa) err_prev = 1;
        end
    endtask

    // Move to the next cycle and apply what the model says happened at that edge.
    task automatic advance();
        @(posedge clk);
        #1;
        if (rst_prev) begin
            m_pend = '0;
            m_owed = '0;
            m_busy = 0;
            m_err  = 0;
            exp_q.delete();
            clr_q.delete();
        end else begin
            while (clr_q.size() > 0 && clr_q[0].cyc <= cyc - 1) begin
                m_pend[clr_q[0].wa] = 1'b0;
                void'(clr_q.pop_front());
            end
            if (err_prev) m_err = 1;
            if (acc_prev) begin
                m_busy = 1;
                m_t    = cyc - 1;
                if (wen_prev) m_pend[wa_prev] = 1'b1;
            end
            if (hs_prev) m_busy = 0;
        end
    endtask

    task automatic tick();
        commit();
        advance();
        iss_valid  = 0;
        res0_valid = 0;
        res1_valid = 0;
    endtask

    task automatic issue(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] u,
                         input logic [AW-1:0] w, input logic we);
        for (int i = 0; i < 40; i++) begin
            iss_valid = 1; iss_ra0 = a0; iss_ra1 = a1; iss_use = u; iss_wa = w; iss_wen = we;
            tick();
            if (acc_prev) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL issue_timeout: request not taken within 40 cycles (cycle %0d)", cyc);
    endtask

    task automatic finish_op();
        for (int i = 0; i < 10; i++) begin
            op_ready = 1;
            tick();
            if (!m_busy) break;
        end
        op_ready = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("iss_ready", 32'(iss_ready), 32'(exp_iss_ready));
            chk("op_valid", 32'(op_valid), 32'(exp_op_valid));
            chk("pending", pending, exp_pend);
            chk("wb_err", 32'(wb_err), 32'(exp_err));
            chk("read", 32'(read), 32'(exp_read));
            if (exp_read[0]) chk("ra0", 32'(ra0), 32'(iss_ra0));
            if (exp_read[1]) chk("ra1", 32'(ra1), 32'(iss_ra1));
            if (op_valid) begin
                if (exp_q.size() == 0) begin
                    chk("op_unexpected", 32'(op_valid), 32'h0);
                end else begin
                    chk("op_a", op_a, exp_q[0].a);
                    chk("op_b", op_b, exp_q[0].b);
                    chk("op_wa_wen", 32'({op_wa, op_wen}), 32'({exp_q[0].wa, exp_q[0].wen}));
                    if (op_ready) void'(exp_q.pop_front());
                end
            end
            if (wb_q0.size() > 0 && wb_q0[0].cyc == cyc) begin
                chk("write0", 32'(write[0]), 32'h1);
                chk("wa0", 32'(wa0), 32'(wb_q0[0].wa));
                chk("wd0", wd0, wb_q0[0].wd);
                void'(wb_q0.pop_front());
            end else if (write[0]) begin
                chk("write0_spurious", 32'(write[0]), 32'h0);
            end
            if (wb_q1.size() > 0 && wb_q1[0].cyc == cyc) begin
                chk("write1", 32'(write[1]), 32'h1);
                chk("wa1", 32'(wa1), 32'(wb_q1[0].wa));
                chk("wd1", wd1, wb_q1[0].wd);
                void'(wb_q1.pop_front());
            end else if (write[1]) begin
                chk("write1_spurious", 32'(write[1]), 32'h0);
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_ra", 32'({ra0, ra1}), 32'h0);
        chk("rst_read_write", 32'({read, write, op_valid}), 32'h0);
        chk("rst_op_a", op_a, 32'h0);
        chk("rst_op_b", op_b, 32'h0);
        chk("rst_op_wa_wen", 32'({op_wa, op_wen}), 32'h0);
        chk("rst_wa", 32'({wa0, wa1}), 32'h0);
        chk("rst_wd0", wd0, 32'h0);
        chk("rst_wd1", wd1, 32'h0);
        chk("rst_pending", pending, 32'h0);
        chk("rst_wb_err", 32'(wb_err), 32'h0);
        chk("rst_iss_ready", 32'(iss_ready), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ol[$];
        int k;
        for (int i = 0; i < NR; i++) m_rf[i] = init_val(i);
        // reset with active stimulus on every input
        rst = 1; op_ready = 1;
        iss_valid = 1; iss_ra0 = 5'd3; iss_ra1 = 5'd4; iss_use = 2'b11; iss_wa = 5'd6; iss_wen = 1;
        res0_valid = 1; res0_wa = 5'd1; res0_data = 32'hDEAD_0001;
        res1_valid = 1; res1_wa = 5'd2; res1_data = 32'hDEAD_0002;
        @(posedge clk);
        #1;
        mon_en = 1;
        for (int c = 0; c < 2; c++) begin
            iss_valid = 1; res0_valid = 1; res1_valid = 1; op_ready = 1;
            #2;
            chk_reset_outputs();
            tick();
        end
        rst = 0; op_ready = 0;
        #2;
        chk("ready_after_rst", 32'(iss_ready), 32'h1);
        chk("write_after_rst", 32'(write), 32'h0);
        tick();

        // basic fetch of r3/r4
        issue(5'd3, 5'd4, 2'b11, 5'd0, 1'b0);
        finish_op();

        // RAW stall on r5
        issue(5'd0, 5'd0, 2'b00, 5'd5, 1'b1);
        finish_op();
        for (int c = 0; c < 3; c++) begin
            iss_valid = 1; iss_ra0 = 5'd5; iss_ra1 = 5'd0; iss_use = 2'b01; iss_wa = 5'd0; iss_wen = 0;
            tick();
        end
        iss_valid = 1; iss_ra0 = 5'd5; iss_use = 2'b01; iss_wen = 0;
        res0_valid = 1; res0_wa = 5'd5; res0_data = 32'h0000_ABCD;
        tick();
        issue(5'd5, 5'd0, 2'b01, 5'd0, 1'b0);
        finish_op();

        // backpressure: op_ready low while operands are presented
        issue(5'd4, 5'd3, 2'b11, 5'd6, 1'b0);
        for (int c = 0; c < 7; c++) begin
            op_ready = 0;
            iss_valid = 1; iss_ra0 = 5'd10; iss_use = 2'b01; iss_wen = 0;
            tick();
        end
        finish_op();

        // dual writeback to two pending registers
        issue(5'd0, 5'd0, 2'b00, 5'd7, 1'b1);
        finish_op();
        issue(5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
        finish_op();
        res0_valid = 1; res0_wa = 5'd7; res0_data = 32'h7777_0007;
        res1_valid = 1; res1_wa = 5'd9; res1_data = 32'h9999_0009;
        tick();
        repeat (3) tick();
        issue(5'd7, 5'd9, 2'b11, 5'd0, 1'b0);
        finish_op();

        // randomised traffic
        for (int c = 0; c < 1500; c++) begin
            iss_valid = ($urandom_range(0, 9) < 6);
            iss_ra0   = 5'($urandom_range(0, 15));
            iss_ra1   = 5'($urandom_range(0, 15));
            iss_use   = 2'($urandom_range(0, 3));
            iss_wa    = 5'($urandom_range(0, 15));
            iss_wen   = 1'($urandom_range(0, 1));
            op_ready  = ($urandom_range(0, 3) != 0);
            ol.delete();
            for (int i = 0; i < NR; i++) if (m_owed[i]) ol.push_back(i);
            if (ol.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, ol.size() - 1));
                res0_valid = 1; res0_wa = 5'(ol[k]); res0_data = $urandom;
                ol.delete(k);
            end
            if (ol.size() > 0 && $urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, ol.size() - 1));
                res1_valid = 1; res1_wa = 5'(ol[k]); res1_data = $urandom;
            end
            tick();
        end
        finish_op();
        for (int i = 0; i < NR; i++) begin
            if (m_owed[i]) begin
                res0_valid = 1; res0_wa = 5'(i); res0_data = $urandom;
                tick();
            end
        end
        repeat (3) tick();

        // both result ports hit r20 in one cycle: port 1 data lands, error flagged
        issue(5'd0, 5'd0, 2'b00, 5'd20, 1'b1);
        finish_op();
        res0_valid = 1; res0_wa = 5'd20; res0_data = 32'h2000_0A0A;
        res1_valid = 1; res1_wa = 5'd20; res1_data = 32'h2000_0B0B;
        tick();
        repeat (2) tick();
        issue(5'd20, 5'd20, 2'b11, 5'd0, 1'b0);
        finish_op();

        // reset in the middle of a fetch drops it, its pending bit and the error flag
        issue(5'd3, 5'd4, 2'b11, 5'd8, 1'b1);
        rst = 1; op_ready = 0;
        tick();
        rst = 0;
        tick();
        issue(5'd8, 5'd0, 2'b01, 5'd8, 1'b0);
        finish_op();

        // result to a register that is not pending
        res0_valid = 1; res0_wa = 5'd12; res0_data = 32'h0000_1212;
        tick();
        repeat (3) tick();
        #2;
        chk("wb_err_sticky", 32'(wb_err), 32'h1);
        issue(5'd12, 5'd0, 2'b01, 5'd0, 1'b0);
        finish_op();
        repeat (3) tick();

        @(negedge clk);
        mon_en = 0;
        if (exp_q.size() != 0 || wb_q0.size() != 0 || wb_q1.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d ops, %0d/%0d writes still expected", exp_q.size(), wb_q0.size(), wb_q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
